// File: rtl/nibble_sum_accum.sv
// nibble_sum_accum
// Buffers 4-bit sums from the nibble-adder stage in a small FIFO and drains
// one entry per cycle into a running accumulator with a sticky overflow flag.
// Optional build macro: NIBBLE_ACC_SATURATE_EN -- when defined, an overflowing
// pop clamps the accumulator at all-ones instead of wrapping.
module nibble_sum_accum #(
  parameter int DEPTH = 4,
  parameter int ACC_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [3:0]               in_data,
  output logic                     in_ready,
  input  logic                     hold,
  input  logic                     clear,
  output logic [ACC_W-1:0]         acc_out,
  output logic                     acc_ovf,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [3:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fill_q;
  logic [ACC_W-1:0] acc_q;
  logic             ovf_q;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_nxt;

  // Occupancy flags and handshake qualifiers; clear blocks both push and pop.
  always_comb begin
    full     = (fill_q == CNT_W'(DEPTH));
    empty    = (fill_q == '0);
    in_ready = !full && !clear;
    push     = in_valid && in_ready;
    pop      = !empty && !hold && !clear;
  end

  // Widened sum of accumulator and head entry; the top bit flags overflow.
  always_comb begin
    sum = {1'b0, acc_q} + {{(ACC_W-3){1'b0}}, mem[rd_ptr]};
`ifdef NIBBLE_ACC_SATURATE_EN
    if (sum[ACC_W]) begin
      acc_nxt = '1;
    end else begin
      acc_nxt = sum[ACC_W-1:0];
    end
`else
    acc_nxt = sum[ACC_W-1:0];
`endif
  end

  // Storage array; data words carry no reset, only pointers and count do.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill_q <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fill_q <= fill_q + CNT_W'(1);
        2'b01:   fill_q <= fill_q - CNT_W'(1);
        default: fill_q <= fill_q;
      endcase
    end
  end

  // Accumulator and sticky overflow, updated on every pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (clear) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (pop) begin
      acc_q <= acc_nxt;
      if (sum[ACC_W]) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Status outputs come straight from registered state.
  always_comb begin
    acc_out = acc_q;
    acc_ovf = ovf_q;
    fill    = fill_q;
    busy    = (fill_q != '0);
  end

endmodule

// File: tb/tb_nibble_sum_accum.sv
// tb_nibble_sum_accum
// Scoreboard bench: accepted pushes are queued, pops consume the queue head
// into a reference total, and outputs are compared after every edge.
// Honors NIBBLE_ACC_SATURATE_EN for expected overflow behavior.
module tb_nibble_sum_accum;

  localparam int DEPTH = 4;
  localparam int ACC_W = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [3:0]       in_data;
  logic             in_ready;
  logic             hold;
  logic             clear;
  logic [ACC_W-1:0] acc_out;
  logic             acc_ovf;
  logic [2:0]       fill;
  logic             busy;

  int errors = 0;
  int checks = 0;

  logic [3:0]       sb_q [$];
  logic [ACC_W-1:0] m_acc;
  logic             m_ovf;

  nibble_sum_accum #(.DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .hold     (hold),
    .clear    (clear),
    .acc_out  (acc_out),
    .acc_ovf  (acc_ovf),
    .fill     (fill),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_val("acc_out", acc_out, m_acc);
    check_val("acc_ovf", acc_ovf, m_ovf);
    check_val("fill", fill, sb_q.size());
    check_val("busy", busy, sb_q.size() != 0);
  endtask

  // One clock cycle: drive inputs, check handshake, advance model across edge.
  task automatic cycle(input logic v, input logic [3:0] d, input logic h, input logic c);
    logic           exp_rdy;
    logic           do_push;
    logic           do_pop;
    logic [ACC_W:0] s;
    in_valid = v;
    in_data  = d;
    hold     = h;
    clear    = c;
    #1;
    exp_rdy = (sb_q.size() != DEPTH) && !c;
    check_val("in_ready", in_ready, exp_rdy);
    do_push = v && exp_rdy;
    do_pop  = (sb_q.size() != 0) && !h && !c;
    @(posedge clk);
    if (c) begin
      sb_q.delete();
      m_acc = '0;
      m_ovf = 1'b0;
    end else begin
      if (do_pop) begin
        s = {1'b0, m_acc} + (ACC_W+1)'(sb_q.pop_front());
        if (s[ACC_W]) begin
          m_ovf = 1'b1;
`ifdef NIBBLE_ACC_SATURATE_EN
          m_acc = '1;
`else
          m_acc = s[ACC_W-1:0];
`endif
        end else begin
          m_acc = s[ACC_W-1:0];
        end
      end
      if (do_push) sb_q.push_back(d);
    end
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 4'h0;
    hold     = 1'b0;
    clear    = 1'b0;
    m_acc    = '0;
    m_ovf    = 1'b0;
    #2;
    check_val("rst_acc", acc_out, 0);
    check_val("rst_ovf", acc_ovf, 0);
    check_val("rst_fill", fill, 0);
    check_val("rst_busy", busy, 0);
    #10;
    rst_n = 1'b1;
    #1;
    check_val("rst_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Streaming: 3, 5, F
    cycle(1'b1, 4'h3, 1'b0, 1'b0);
    check_val("stream_acc0", acc_out, 0);
    cycle(1'b1, 4'h5, 1'b0, 1'b0);
    check_val("stream_acc1", acc_out, 3);
    check_val("stream_fill1", fill, 1);
    cycle(1'b1, 4'hF, 1'b0, 1'b0);
    check_val("stream_acc2", acc_out, 8);
    cycle(1'b0, 4'h0, 1'b0, 1'b0);
    check_val("stream_acc3", acc_out, 23);
    check_val("stream_ovf", acc_ovf, 0);
    idle(1);

    // Hold / back-pressure
    cycle(1'b0, 4'h0, 1'b0, 1'b1);
    for (int i = 1; i <= 5; i++) cycle(1'b1, 4'(i), 1'b1, 1'b0);
    check_val("hold_fill", fill, 4);
    check_val("hold_ready", in_ready, 0);
    cycle(1'b0, 4'h0, 1'b0, 1'b0);
    check_val("hold_ready_back", in_ready, 1);
    idle(3);
    check_val("hold_acc", acc_out, 10);

    // Overflow
    cycle(1'b0, 4'h0, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) cycle(1'b1, 4'hF, 1'b0, 1'b0);
    idle(2);
    check_val("pre_ovf_acc", acc_out, 255);
    check_val("pre_ovf_flag", acc_ovf, 0);
    cycle(1'b1, 4'h1, 1'b0, 1'b0);
    idle(1);
`ifdef NIBBLE_ACC_SATURATE_EN
    check_val("ovf_acc", acc_out, 255);
`else
    check_val("ovf_acc", acc_out, 0);
`endif
    check_val("ovf_flag", acc_ovf, 1);
    cycle(1'b1, 4'h2, 1'b0, 1'b0);
    idle(1);
`ifdef NIBBLE_ACC_SATURATE_EN
    check_val("ovf_acc2", acc_out, 255);
`else
    check_val("ovf_acc2", acc_out, 2);
`endif
    check_val("ovf_sticky", acc_ovf, 1);

    // Simultaneous push/pop at fill=2, order preserved
    cycle(1'b0, 4'h0, 1'b0, 1'b1);
    cycle(1'b1, 4'h1, 1'b1, 1'b0);
    cycle(1'b1, 4'h2, 1'b1, 1'b0);
    cycle(1'b1, 4'h3, 1'b0, 1'b0);
    check_val("pp_fill_a", fill, 2);
    check_val("pp_acc_a", acc_out, 1);
    cycle(1'b1, 4'h4, 1'b0, 1'b0);
    check_val("pp_fill_b", fill, 2);
    check_val("pp_acc_b", acc_out, 3);
    cycle(1'b0, 4'h0, 1'b0, 1'b0);
    check_val("pp_acc_c", acc_out, 6);
    cycle(1'b0, 4'h0, 1'b0, 1'b0);
    check_val("pp_acc_d", acc_out, 10);

    // Clear mid-stream with overflow set and fill=3
    cycle(1'b0, 4'h0, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) cycle(1'b1, 4'hF, 1'b0, 1'b0);
    cycle(1'b1, 4'hF, 1'b0, 1'b0);
    cycle(1'b1, 4'h3, 1'b0, 1'b0);
    idle(2);
    check_val("pre_clr_ovf", acc_ovf, 1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'h6, 1'b1, 1'b0);
    check_val("pre_clr_fill", fill, 3);
    cycle(1'b1, 4'h9, 1'b1, 1'b1);
    check_val("clr_fill", fill, 0);
    check_val("clr_acc", acc_out, 0);
    check_val("clr_ovf", acc_ovf, 0);
    cycle(1'b0, 4'h0, 1'b0, 1'b0);
    check_val("clr_absent", acc_out, 0);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'h5, 1'b1, 1'b0);
    cycle(1'b0, 4'h0, 1'b0, 1'b0);
    in_valid = 1'b0;
    hold     = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_fill", fill, 0);
    check_val("arst_acc", acc_out, 0);
    check_val("arst_busy", busy, 0);
    check_val("arst_ovf", acc_ovf, 0);
    sb_q.delete();
    m_acc = '0;
    m_ovf = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b1, 4'h7, 1'b0, 1'b0);
    cycle(1'b0, 4'h0, 1'b0, 1'b0);
    check_val("arst_acc7", acc_out, 7);

    // Random traffic against the scoreboard
    for (int i = 0; i < 200; i++) begin
      cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 39) == 0));
    end
    idle(DEPTH + 1);
    check_val("final_empty", fill, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
